// File: rtl/cache_pkg.sv
// cache_pkg: shared cache geometry defaults and the refill engine state encoding.
package cache_pkg;
    localparam int SIZE_BLOCK_DEF = 32;
    localparam int BIT_TOTAL_DEF = 24;
    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP} filler_state_t;
endpackage

// File: rtl/cache_ro_filler_if.sv
// cache_ro_filler_if: client request/response, cache_ro port and memory read port of the refill engine.
interface cache_ro_filler_if
    import cache_pkg::*;
#(
    parameter int SIZE_BLOCK = SIZE_BLOCK_DEF,
    parameter int BIT_TOTAL = BIT_TOTAL_DEF
);
    logic req_valid;
    logic req_ready;
    logic [BIT_TOTAL-1:0] req_addr;
    logic resp_valid;
    logic [SIZE_BLOCK-1:0] resp_data;
    logic c_en;
    logic c_wrt;
    logic [BIT_TOTAL-1:0] c_addr;
    logic [SIZE_BLOCK-1:0] c_data;
    logic [SIZE_BLOCK-1:0] c_rdata;
    logic c_success;
    logic mem_rd;
    logic [BIT_TOTAL-1:0] mem_addr;
    logic mem_wait;
    logic mem_rdata_valid;
    logic [SIZE_BLOCK-1:0] mem_rdata;
    modport master (
        input req_valid, req_addr, c_rdata, c_success, mem_wait, mem_rdata_valid, mem_rdata,
        output req_ready, resp_valid, resp_data, c_en, c_wrt, c_addr, c_data, mem_rd, mem_addr
    );
    modport slave (
        output req_valid, req_addr, c_rdata, c_success, mem_wait, mem_rdata_valid, mem_rdata,
        input req_ready, resp_valid, resp_data, c_en, c_wrt, c_addr, c_data, mem_rd, mem_addr
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!rst) count <= '0;
        else if (inc && !(&count)) count <= count + 1'b1;
    end
endmodule

// File: rtl/cache_ro_filler.sv
// cache_ro_filler: single-request lookup/refill engine in front of cache_ro,
// fetching misses from external memory and counting hits and misses.
module cache_ro_filler
    import cache_pkg::*;
#(
    parameter int SIZE_BLOCK = SIZE_BLOCK_DEF,
    parameter int BIT_TOTAL = BIT_TOTAL_DEF,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst,
    cache_ro_filler_if.master bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic err
);
    filler_state_t state, next;
    logic [BIT_TOTAL-1:0] addr_q;
    logic [SIZE_BLOCK-1:0] data_q;
    logic drop_q;
    logic take;

    // A read already accepted by memory when reset hits will still return; swallow that one beat.
    assign take = bus.mem_rdata_valid && !drop_q;

    assign bus.req_ready = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.c_en = state == LOOKUP || state == FILL;
    assign bus.c_wrt = state == FILL;
    assign bus.c_addr = addr_q;
    assign bus.c_data = state == FILL ? data_q : '0;
    assign bus.mem_rd = state == MEM_REQ;
    assign bus.mem_addr = addr_q;

    always_comb begin
        next = state;
        case (state)
            IDLE:     if (bus.req_valid) next = LOOKUP;
            LOOKUP:   next = CHECK;
            CHECK:    next = bus.c_success ? RESP : MEM_REQ;
            MEM_REQ:  if (!bus.mem_wait) next = MEM_WAIT;
            MEM_WAIT: if (take) next = FILL;
            FILL:     next = RESP;
            default:  next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            bus.resp_data <= '0;
            err <= 1'b0;
            drop_q <= drop_q || state == MEM_WAIT || (state == MEM_REQ && !bus.mem_wait);
        end else begin
            state <= next;
            if (state == IDLE && bus.req_valid) addr_q <= bus.req_addr;
            if (state == CHECK && bus.c_success) bus.resp_data <= bus.c_rdata;
            if (state == MEM_WAIT && take) data_q <= bus.mem_rdata;
            if (state == FILL) bus.resp_data <= data_q;
            if (bus.mem_rdata_valid) begin
                if (drop_q) drop_q <= 1'b0;
                else if (state != MEM_WAIT) err <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit (
        .clk(clk), .rst(rst), .inc(state == CHECK && bus.c_success), .count(hit_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss (
        .clk(clk), .rst(rst), .inc(state == CHECK && !bus.c_success), .count(miss_count)
    );
endmodule

// File: tb/tb_cache_ro_filler.sv
// tb_cache_ro_filler: directed bench with a 32-set 3-way cache_ro model and a waitstate memory model.
module tb_cache_ro_filler;
    localparam int CW = 3;
    logic clk = 0;
    logic rst = 0;
    logic [CW-1:0] hit_count, miss_count;
    logic err;
    int passed = 0, total = 0;
    cache_ro_filler_if #(.SIZE_BLOCK(32), .BIT_TOTAL(24)) bus();

    cache_ro_filler #(.SIZE_BLOCK(32), .BIT_TOTAL(24), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count), .err(err)
    );

    always #5 clk = ~clk;

    bit [23:0] ctag [32][3];
    bit [31:0] cdat [32][3];
    bit cval [32][3];
    bit [1:0] cptr [32];
    int f, n_wr = 0;
    logic [23:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    function automatic int find(input logic [23:0] a);
        for (int w = 0; w < 3; w++) if (cval[a[4:0]][w] && ctag[a[4:0]][w] == a) return w;
        return -1;
    endfunction

    initial begin
        bus.c_success = 0;
        bus.c_rdata = '0;
    end

    always @(posedge clk) begin
        if (bus.c_en && !bus.c_wrt) begin
            f = find(bus.c_addr);
            bus.c_success <= f >= 0;
            bus.c_rdata <= f >= 0 ? cdat[bus.c_addr[4:0]][f] : 32'h0;
        end
        if (bus.c_en && bus.c_wrt) begin
            f = find(bus.c_addr);
            if (f < 0) begin
                f = int'(cptr[bus.c_addr[4:0]]);
                cptr[bus.c_addr[4:0]] <= cptr[bus.c_addr[4:0]] == 2 ? 2'd0 : cptr[bus.c_addr[4:0]] + 2'd1;
            end
            cval[bus.c_addr[4:0]][f] <= 1;
            ctag[bus.c_addr[4:0]][f] <= bus.c_addr;
            cdat[bus.c_addr[4:0]][f] <= bus.c_data;
            n_wr <= n_wr + 1;
            wr_addr <= bus.c_addr;
            wr_data <= bus.c_data;
        end
    end

    logic [31:0] mem_arr [0:127];
    int mw = 0, wcnt = 0, n_acc = 0, n_resp = 0;
    bit auto_rsp = 1, rv = 0, spur = 0;
    logic [31:0] rd = '0, spur_d = '0;
    logic [23:0] acc_addr = '0;

    assign bus.mem_wait = bus.mem_rd && (wcnt < mw);
    assign bus.mem_rdata_valid = rv | spur;
    assign bus.mem_rdata = spur ? spur_d : rd;

    always @(posedge clk) begin
        rv <= 0;
        if (bus.mem_rd && bus.mem_wait) wcnt <= wcnt + 1;
        if (bus.mem_rd && !bus.mem_wait) begin
            wcnt <= 0;
            rv <= auto_rsp;
            rd <= mem_arr[bus.mem_addr[6:0]];
            n_acc <= n_acc + 1;
            acc_addr <= bus.mem_addr;
        end
        if (bus.resp_valid) n_resp <= n_resp + 1;
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    endtask

    task automatic send(input logic [23:0] a, output int lat);
        int g = 0;
        while (!bus.req_ready && g < 50) begin @(posedge clk); #1; g++; end
        bus.req_valid = 1;
        bus.req_addr = a;
        @(posedge clk); #1;
        bus.req_valid = 0;
        bus.req_addr = 24'habcde;
        lat = 1;
        while (!bus.resp_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    endtask

    int lat, r0;
    logic [7:0] rv_seq, rr_seq;
    logic [31:0] d1, d2;

    initial begin
        for (int i = 0; i < 128; i++) mem_arr[i] = 32'h1000 + i;
        mem_arr[3] = 32'ha;  mem_arr[0] = 32'he;  mem_arr[32] = 32'h20;
        mem_arr[64] = 32'h40; mem_arr[96] = 32'h60; mem_arr[4] = 32'hb;
        mem_arr[5] = 32'hc;  mem_arr[7] = 32'h77;
        bus.req_valid = 0;
        bus.req_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_c_en", {bus.c_en, bus.c_wrt, bus.mem_rd}, 0);
        chk("rst_err", err, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_addrs", {bus.c_addr, bus.mem_addr, bus.c_data}, 0);
        chk("rst_counts", {hit_count, miss_count}, 0);
        // cold miss with two waitstates
        mw = 2;
        send(24'd3, lat);
        chk("cold_lat", lat, 8);
        chk("cold_data", bus.resp_data, 32'ha);
        chk("cold_acc", {n_acc, 8'h0, acc_addr}, {32'd1, 8'h0, 24'd3});
        chk("cold_fill", {n_wr, wr_data, 8'h0, wr_addr}, {32'd1, 32'ha, 8'h0, 24'd3});
        chk("cold_counts", {hit_count, miss_count}, {3'd0, 3'd1});
        @(posedge clk); #1;
        chk("pulse_one_cycle", {bus.resp_valid, bus.req_ready}, 2'b01);
        chk("resp_hold", bus.resp_data, 32'ha);
        // hit after fill
        mw = 0;
        send(24'd3, lat);
        chk("hit_lat", lat, 3);
        chk("hit_data", bus.resp_data, 32'ha);
        chk("hit_no_mem", n_acc, 1);
        chk("hit_counts", {hit_count, miss_count}, {3'd1, 3'd1});
        send(24'd7, lat);
        chk("miss0_lat", lat, 6);
        chk("miss0_data", bus.resp_data, 32'h77);
        // set-0 conflict: four fills into three ways evict 'd0
        send(24'd0, lat);
        send(24'd32, lat);
        send(24'd64, lat);
        send(24'd96, lat);
        chk("conf_miss_cnt", miss_count, 6);
        send(24'd0, lat);
        chk("conf_lat", lat, 6);
        chk("conf_data", bus.resp_data, 32'he);
        chk("conf_miss_cnt2", miss_count, 7);
        send(24'd4, lat);
        send(24'd5, lat);
        chk("miss_saturate", {hit_count, miss_count}, {3'd1, 3'd7});
        chk("sat_data", bus.resp_data, 32'hc);
        // back-to-back with req_valid held
        @(posedge clk); #1;
        r0 = n_resp;
        bus.req_valid = 1;
        bus.req_addr = 24'd4;
        rv_seq = '0;
        rr_seq = '0;
        d1 = '0;
        d2 = '0;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.req_addr = 24'd5;
            if (i == 5) bus.req_valid = 0;
            rv_seq[i] = bus.resp_valid;
            rr_seq[i] = bus.req_ready;
            if (i == 3) d1 = bus.resp_data;
            if (i == 7) d2 = bus.resp_data;
        end
        chk("b2b_resp_seq", rv_seq, 8'b1000_1000);
        chk("b2b_ready_seq", rr_seq, 8'b0001_0000);
        chk("b2b_data", {d1, d2}, {32'hb, 32'hc});
        chk("b2b_counts", {hit_count, miss_count}, {3'd3, 3'd7});
        @(posedge clk); #1;
        chk("b2b_hold", {bus.resp_valid, bus.resp_data}, {1'b0, 32'hc});
        // reset while waiting for read data
        auto_rsp = 0;
        bus.req_valid = 1;
        bus.req_addr = 24'd9;
        @(posedge clk); #1;
        bus.req_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rw_mem_rd", {bus.mem_rd, bus.mem_addr}, {1'b1, 24'd9});
        @(posedge clk); #1;
        chk("rw_in_wait", {bus.mem_rd, bus.resp_valid}, 2'b00);
        r0 = n_resp;
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
        chk("rw_idle", {bus.req_ready, bus.c_en, bus.mem_rd}, 3'b100);
        chk("rw_counts", {hit_count, miss_count}, 0);
        spur = 1;
        spur_d = 32'hdead;
        @(posedge clk); #1;
        spur = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rw_late_err", err, 0);
        chk("rw_no_resp", n_resp, r0);
        chk("rw_ready", bus.req_ready, 1);
        // spurious read data while idle
        auto_rsp = 1;
        spur = 1;
        spur_d = 32'hbad;
        @(posedge clk); #1;
        spur = 0;
        chk("spur_err", err, 1);
        repeat (2) @(posedge clk);
        #1 chk("spur_sticky", err, 1);
        send(24'd3, lat);
        chk("post_hit", {lat, bus.resp_data}, {32'd3, 32'ha});
        send(24'd96, lat);
        chk("post_hit2", {lat, bus.resp_data}, {32'd3, 32'h60});
        send(24'd10, lat);
        chk("post_miss", {lat, bus.resp_data}, {32'd6, 32'h100a});
        chk("post_counts", {hit_count, miss_count, err}, {3'd2, 3'd1, 1'b1});
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
